nou_resp_enc: RTL and testbench

Response-side counterpart to the NOU request decode registers. Collects completion/status responses from the four request consumers and serializes them onto one host-facing response channel:
- IRR: invalid-request reporter
- BRR: buffer manager
- PWRR: whitelist manager
- SPR: send engine

Each source has a small FIFO. Sources are served round-robin into a registered valid/ready output stage.

---
 rtl/nou_resp_pkg.sv | 41 ++++
 rtl/nou_resp_fifo.sv | 64 ++++++
 rtl/nou_resp_enc.sv | 124 ++++++++++++
 tb/tb_nou_resp_enc.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nou_resp_pkg.sv
// Shared definitions for the NOU response encoder.
// Holds the source count and index map, the status code values, the default
// field widths and the packed response record used on the host channel.
package nou_resp_pkg;

    localparam int unsigned NSRC  = 4;
    localparam int unsigned SRC_W = 2;

    localparam int unsigned SID_W_DEF  = 8;
    localparam int unsigned STAT_W_DEF = 4;
    localparam int unsigned PLD_W_DEF  = 16;

    // Fixed source index map
    localparam logic [SRC_W-1:0] SRC_IRR  = 2'd0;
    localparam logic [SRC_W-1:0] SRC_BRR  = 2'd1;
    localparam logic [SRC_W-1:0] SRC_PWRR = 2'd2;
    localparam logic [SRC_W-1:0] SRC_SPR  = 2'd3;

    // Status codes carried in the stat field
    localparam logic [STAT_W_DEF-1:0] ST_OK       = 4'd0;
    localparam logic [STAT_W_DEF-1:0] ST_BAD_TYPE = 4'd1;
    localparam logic [STAT_W_DEF-1:0] ST_NO_BUF   = 4'd2;
    localparam logic [STAT_W_DEF-1:0] ST_WL_FULL  = 4'd3;
    localparam logic [STAT_W_DEF-1:0] ST_NOT_WL   = 4'd4;
    localparam logic [STAT_W_DEF-1:0] ST_BUSY     = 4'd5;

    typedef struct packed {
        logic [SRC_W-1:0]      src;
        logic [SID_W_DEF-1:0]  sid;
        logic [STAT_W_DEF-1:0] stat;
        logic [PLD_W_DEF-1:0]  pld;
    } rsp_t;

    // Round-robin successor of a source index
    function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] idx);
        int unsigned nxt;
        nxt = (int'(idx) + 1) % NSRC;
        return SRC_W'(nxt);
    endfunction

endpackage

// File: rtl/nou_resp_fifo.sv
// Small synchronous circular-buffer FIFO, one per response source.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   push, wdata   - write request and data (ignored while full)
//   pop           - read request (ignored while empty)
//   rdata         - head entry, valid while !empty
//   full, empty   - occupancy flags from the registered count
module nou_resp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);

    // Full refuses a push even if the same cycle pops
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/nou_resp_enc.sv
// NOU response encoder: per-source FIFOs drained round-robin into a single
// registered valid/ready host response channel.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   src_vld/src_rdy                - per-source handshake (rdy = FIFO not full)
//   src_sid/src_stat/src_pld       - per-source fields, source i at [i*W +: W]
//   rsp_vld/rsp_rdy                - host handshake
//   rsp_src/sid/stat/pld           - presented response
//   rsp_cnt                        - number of accepted responses (wraps)
module nou_resp_enc
    import nou_resp_pkg::*;
#(
    parameter int unsigned SID_W  = SID_W_DEF,
    parameter int unsigned STAT_W = STAT_W_DEF,
    parameter int unsigned PLD_W  = PLD_W_DEF,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NSRC-1:0]        src_vld,
    output logic [NSRC-1:0]        src_rdy,
    input  logic [NSRC*SID_W-1:0]  src_sid,
    input  logic [NSRC*STAT_W-1:0] src_stat,
    input  logic [NSRC*PLD_W-1:0]  src_pld,
    output logic                   rsp_vld,
    input  logic                   rsp_rdy,
    output logic [SRC_W-1:0]       rsp_src,
    output logic [SID_W-1:0]       rsp_sid,
    output logic [STAT_W-1:0]      rsp_stat,
    output logic [PLD_W-1:0]       rsp_pld,
    output logic [CNT_W-1:0]       rsp_cnt
);

    localparam int unsigned ENT_W = SID_W + STAT_W + PLD_W;

    logic [NSRC-1:0]  full, empty, push, pop;
    logic [ENT_W-1:0] head [NSRC];

    logic             ld;
    logic             gnt_vld;
    logic [SRC_W-1:0] gnt_idx;
    logic [SRC_W-1:0] rr_q;

    logic              vld_q;
    logic [SRC_W-1:0]  src_q;
    logic [SID_W-1:0]  sid_q;
    logic [STAT_W-1:0] stat_q;
    logic [PLD_W-1:0]  pld_q;
    logic [CNT_W-1:0]  cnt_q;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        // Ready is held low during reset so nothing is captured then
        assign src_rdy[i] = !full[i] && !rst;
        assign push[i]    = src_vld[i] && src_rdy[i];

        nou_resp_fifo #(
            .WIDTH (ENT_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .wdata ({src_sid[i*SID_W +: SID_W],
                     src_stat[i*STAT_W +: STAT_W],
                     src_pld[i*PLD_W +: PLD_W]}),
            .pop   (pop[i]),
            .rdata (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    assign ld = !vld_q || rsp_rdy;

    // First non-empty source at or above the RR pointer, modulo NSRC
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NSRC; k++) begin
            int unsigned cand;
            cand = (int'(rr_q) + k) % NSRC;
            if (!gnt_vld && !empty[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = SRC_W'(cand);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (ld && gnt_vld) pop[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q   <= '0;
            vld_q  <= 1'b0;
            src_q  <= '0;
            sid_q  <= '0;
            stat_q <= '0;
            pld_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (vld_q && rsp_rdy) cnt_q <= cnt_q + CNT_W'(1);
            if (ld) begin
                vld_q <= gnt_vld;
                if (gnt_vld) begin
                    src_q                   <= gnt_idx;
                    {sid_q, stat_q, pld_q}  <= head[gnt_idx];
                    rr_q                    <= next_src(gnt_idx);
                end
            end
        end
    end

    assign rsp_vld  = vld_q;
    assign rsp_src  = src_q;
    assign rsp_sid  = sid_q;
    assign rsp_stat = stat_q;
    assign rsp_pld  = pld_q;
    assign rsp_cnt  = cnt_q;

endmodule

// File: tb/tb_nou_resp_enc.sv
// Self-checking bench for nou_resp_enc: directed table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_nou_resp_enc;
    import nou_resp_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  src_rdy;
    logic [31:0] sid;
    logic [15:0] stat;
    logic [63:0] pld;
    logic        rsp_vld, rdy;
    logic [1:0]  rsp_src;
    logic [7:0]  rsp_sid;
    logic [3:0]  rsp_stat;
    logic [15:0] rsp_pld;
    logic [15:0] rsp_cnt;

    always #5 clk = ~clk;

    nou_resp_enc #(
        .SID_W  (8),
        .STAT_W (4),
        .PLD_W  (16),
        .DEPTH  (DEPTH),
        .CNT_W  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src_vld  (vld),
        .src_rdy  (src_rdy),
        .src_sid  (sid),
        .src_stat (stat),
        .src_pld  (pld),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rdy),
        .rsp_src  (rsp_src),
        .rsp_sid  (rsp_sid),
        .rsp_stat (rsp_stat),
        .rsp_pld  (rsp_pld),
        .rsp_cnt  (rsp_cnt)
    );

    // Reference model: one queue per source plus the presented response
    rsp_t        mq [4][$];
    bit          m_vld;
    rsp_t        m_rsp;
    int          m_rr;
    logic [15:0] m_cnt;
    int          xfers;

    int nvec = 0;
    int nerr = 0;
    logic [25:0] obs [$];   // {src, sid, pld} of every observed transfer

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    // Compare DUT against the model at the falling edge
    task automatic sample();
        logic [3:0] e_rdy;
        bit bad;
        @(negedge clk);
        for (int i = 0; i < 4; i++) e_rdy[i] = !rst && (mq[i].size() < DEPTH);
        bad = (rsp_vld !== m_vld) || (rsp_cnt !== m_cnt) || (src_rdy !== e_rdy);
        if (m_vld && ({rsp_src, rsp_sid, rsp_stat, rsp_pld} !== m_rsp)) bad = 1;
        nvec++;
        if (bad) begin
            nerr++;
            $display("FAIL model t=%0t got vld=%0d rsp=%0h cnt=%0h rdy=%0h exp vld=%0d rsp=%0h cnt=%0h rdy=%0h",
                     $time, rsp_vld, {rsp_src, rsp_sid, rsp_stat, rsp_pld}, rsp_cnt, src_rdy,
                     m_vld, m_rsp, m_cnt, e_rdy);
        end
        if (rsp_vld && rdy) obs.push_back({rsp_src, rsp_sid, rsp_pld});
    endtask

    // Advance the model across the rising edge, then the DUT
    task automatic advance();
        bit   acc [4];
        bit   found;
        int   idx;
        rsp_t e;
        if (rst) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_vld = 0;
            m_rr  = 0;
            m_cnt = '0;
        end else begin
            for (int i = 0; i < 4; i++) acc[i] = vld[i] && (mq[i].size() < DEPTH);
            if (m_vld && rdy) begin
                m_cnt = m_cnt + 16'd1;
                xfers++;
            end
            if (!m_vld || rdy) begin
                found = 0;
                for (int k = 0; k < 4; k++) begin
                    idx = (m_rr + k) % 4;
                    if (!found && mq[idx].size() > 0) begin
                        m_rsp = mq[idx].pop_front();
                        m_rr  = (idx + 1) % 4;
                        found = 1;
                    end
                end
                m_vld = found;
            end
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    e.src  = 2'(i);
                    e.sid  = sid[i*8 +: 8];
                    e.stat = stat[i*4 +: 4];
                    e.pld  = pld[i*16 +: 16];
                    mq[i].push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst = 1; vld = '0;
        cycle();
        rst = 0;
    endtask

    task automatic rand_fields();
        sid  = $urandom;
        stat = 16'($urandom);
        pld  = {$urandom, $urandom};
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  v;
        logic        y;
        logic        c;
        logic        f;
        logic        e_vld;
        logic [1:0]  e_src;
        logic [7:0]  e_sid;
        logic [15:0] e_pld;
        logic [15:0] e_cnt;
        logic [3:0]  e_rdy;
    } vec_t;

    vec_t tbl [6];
    logic [25:0] exp_e;
    int budget;

    initial begin
        rst = 1; vld = '0; rdy = 1; sid = '0; stat = '0; pld = '0;
        m_vld = 0; m_rr = 0; m_cnt = '0; xfers = 0; m_rsp = '0;

        // Single push from BRR after reset
        tbl[0] = '{1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 16'h0000, 16'd0, 4'h0};
        tbl[1] = '{1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 16'h0000, 16'd0, 4'h0};
        tbl[2] = '{1'b0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 16'h0000, 16'd0, 4'hF};
        tbl[3] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 16'h0000, 16'd0, 4'hF};
        tbl[4] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 8'h12, 16'h0040, 16'd0, 4'hF};
        tbl[5] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 16'h0000, 16'd1, 4'hF};
        sid = {4{8'h12}}; stat = '0; pld = {4{16'h0040}};
        for (int n = 0; n < 6; n++) begin
            rst = tbl[n].r; vld = tbl[n].v; rdy = tbl[n].y;
            sample();
            if (tbl[n].c) begin
                chk("tbl_ctl", {rsp_vld, rsp_cnt, src_rdy}, {tbl[n].e_vld, tbl[n].e_cnt, tbl[n].e_rdy});
                if (tbl[n].f)
                    chk("tbl_fld", {rsp_src, rsp_sid, rsp_pld},
                        {tbl[n].e_src, tbl[n].e_sid, tbl[n].e_pld});
            end
            advance();
        end

        // All sources push two entries together: expect 0,1,2,3,0,1,2,3
        do_reset();
        rdy = 1; obs.delete();
        for (int b = 0; b < 2; b++) begin
            vld = 4'hF;
            for (int i = 0; i < 4; i++) begin
                sid[i*8 +: 8]   = 8'(8'h20 + 16 * b + i);
                pld[i*16 +: 16] = 16'(16'h100 * (b + 1) + i);
            end
            cycle();
        end
        vld = '0;
        repeat (12) cycle();
        chk("rr_count", 64'(obs.size()), 64'd8);
        for (int n = 0; n < 8 && n < obs.size(); n++) begin
            exp_e = {2'(n % 4), 8'(8'h20 + 16 * (n / 4) + n % 4), 16'(16'h100 * (n / 4 + 1) + n % 4)};
            chk("rr_order", 64'(obs[n]), 64'(exp_e));
        end

        // Backpressure: PWRR pushes three entries while host stalls
        do_reset();
        rdy = 0; obs.delete();
        for (int k = 0; k < 3; k++) begin
            vld = 4'h4;
            sid[16 +: 8] = 8'(8'h40 + k);
            pld[32 +: 16] = 16'(16'h0A00 + k);
            cycle();
        end
        vld = 4'h4; sid[16 +: 8] = 8'h4F;
        for (int k = 0; k < 10; k++) begin
            sample();
            chk("bp_hold", {rsp_vld, rsp_src, rsp_sid, src_rdy[2]}, {1'b1, 2'd2, 8'h40, 1'b0});
            advance();
        end
        vld = '0; rdy = 1;
        repeat (6) cycle();
        chk("bp_count", 64'(obs.size()), 64'd3);
        for (int n = 0; n < 3 && n < obs.size(); n++)
            chk("bp_order", 64'(obs[n]), 64'({2'd2, 8'(8'h40 + n), 16'(16'h0A00 + n)}));

        // Full boundary: a full FIFO refuses a push even while popping
        do_reset();
        rdy = 0; obs.delete();
        for (int k = 0; k < 3; k++) begin
            vld = 4'h1; sid[7:0] = 8'(8'h50 + k); pld[15:0] = 16'(k);
            cycle();
        end
        rdy = 1; vld = 4'h1; sid[7:0] = 8'h53; pld[15:0] = 16'd3;
        sample();
        chk("full_refuse", 64'(src_rdy[0]), 64'd0);
        advance();
        sample();
        chk("full_accept", 64'(src_rdy[0]), 64'd1);
        advance();
        vld = '0;
        repeat (6) cycle();
        chk("full_count", 64'(obs.size()), 64'd4);
        for (int n = 0; n < 4 && n < obs.size(); n++)
            chk("full_order", 64'(obs[n]), 64'({2'd0, 8'(8'h50 + n), 16'(n)}));

        // Mid-stream reset discards everything queued
        rdy = 0; vld = 4'hF;
        repeat (3) begin
            rand_fields();
            cycle();
        end
        rst = 1;
        sample();
        chk("rst_rdy", 64'(src_rdy), 64'h0);
        advance();
        rst = 0; vld = '0; rdy = 1; obs.delete();
        sample();
        chk("rst_state", {rsp_vld, rsp_cnt, src_rdy}, {1'b0, 16'd0, 4'hF});
        advance();
        repeat (5) cycle();
        chk("rst_stale", 64'(obs.size()), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            vld = 4'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
            rand_fields();
            cycle();
        end
        rst = 0;

        // Counter wrap: saturate all sources so one transfer happens per cycle
        do_reset();
        vld = 4'hF; rdy = 1; xfers = 0; budget = 0;
        while (xfers < 65538 && budget < 70000) begin
            rand_fields();
            cycle();
            budget++;
            if (xfers == 65536 && m_vld) begin
                sample();
                chk("cnt_wrap0", 64'(rsp_cnt), 64'd0);
                advance();
                budget++;
            end
        end
        chk("wrap_budget", 64'(xfers >= 65538), 64'd1);
        sample();
        chk("cnt_wrap2", 64'(rsp_cnt), 64'(16'(xfers)));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
